// File: rtl/core_cache_bus_arbiter.sv
// Shares the cache refill/writeback bus between I-cache (master 0) and D-cache (master 1), one burst at a time.
// Optional macro CACHE_BUS_ARB_RR_EN: round-robin tie break; otherwise master 1 wins ties.
module core_cache_bus_arbiter #(
    parameter int LEN_W  = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req_valid_i,
    output logic [1:0]             req_ready_o,
    input  logic [1:0][ADDR_W-1:0] req_addr_i,
    input  logic [1:0]             req_we_i,
    input  logic [1:0][LEN_W-1:0]  req_len_i,
    input  logic [1:0]             wdata_valid_i,
    input  logic [1:0][DATA_W-1:0] wdata_i,
    output logic [1:0]             wdata_ready_o,
    output logic [1:0]             rdata_valid_o,
    output logic [DATA_W-1:0]      rdata_o,
    output logic                   rdata_last_o,
    output logic [1:0]             wresp_valid_o,
    output logic                   bus_req_valid_o,
    input  logic                   bus_req_ready_i,
    output logic [ADDR_W-1:0]      bus_addr_o,
    output logic                   bus_we_o,
    output logic [LEN_W-1:0]       bus_len_o,
    output logic                   bus_wdata_valid_o,
    output logic [DATA_W-1:0]      bus_wdata_o,
    output logic                   bus_wdata_last_o,
    input  logic                   bus_wdata_ready_i,
    input  logic                   bus_rdata_valid_i,
    input  logic [DATA_W-1:0]      bus_rdata_i,
    input  logic                   bus_rdata_last_i,
    input  logic                   bus_wresp_valid_i,
    output logic                   busy_o
);
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_WRESP, S_RDATA} state_t;

    state_t             r_state, w_state_nxt;
    logic               r_grant;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_we;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_cnt;
    logic               w_sel;
    logic               w_grant_now;
    logic               w_whs;
    logic               w_wlast;

    assign w_grant_now = (r_state == S_IDLE) && (|req_valid_i);

`ifdef CACHE_BUS_ARB_RR_EN
    // r_last holds the master granted most recently; reset value 1 lets master 0 win the first tie
    logic r_last;
    assign w_sel = (req_valid_i == 2'b11) ? ~r_last : req_valid_i[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           r_last <= 1'b1;
        else if (w_grant_now) r_last <= w_sel;
    end
`else
    assign w_sel = req_valid_i[1];
`endif

    assign w_wlast = (r_cnt == r_len);
    assign w_whs   = (r_state == S_WDATA) && wdata_valid_i[r_grant] && bus_wdata_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_grant <= 1'b0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_len   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_now) begin
                r_grant <= w_sel;
                r_addr  <= req_addr_i[w_sel];
                r_we    <= req_we_i[w_sel];
                r_len   <= req_len_i[w_sel];
            end
            // clearing on the last beat keeps the counter from ever wrapping at len=2**LEN_W-1
            if (w_whs) r_cnt <= w_wlast ? '0 : r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        req_ready_o       = 2'b00;
        wdata_ready_o     = 2'b00;
        rdata_valid_o     = 2'b00;
        rdata_o           = '0;
        rdata_last_o      = 1'b0;
        wresp_valid_o     = 2'b00;
        bus_req_valid_o   = 1'b0;
        bus_wdata_valid_o = 1'b0;
        bus_wdata_o       = '0;
        bus_wdata_last_o  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|req_valid_i) begin
                    w_state_nxt        = S_ADDR;
                    // gated so the grant pulse cannot leak out while reset is held
                    req_ready_o[w_sel] = rst_n;
                end
            end
            S_ADDR: begin
                bus_req_valid_o = 1'b1;
                if (bus_req_ready_i) w_state_nxt = r_we ? S_WDATA : S_RDATA;
            end
            S_WDATA: begin
                bus_wdata_valid_o      = wdata_valid_i[r_grant];
                bus_wdata_o            = wdata_i[r_grant];
                wdata_ready_o[r_grant] = bus_wdata_ready_i;
                bus_wdata_last_o       = w_wlast;
                if (w_whs && w_wlast) w_state_nxt = S_WRESP;
            end
            S_WRESP: begin
                if (bus_wresp_valid_i) begin
                    wresp_valid_o[r_grant] = 1'b1;
                    w_state_nxt            = S_IDLE;
                end
            end
            S_RDATA: begin
                rdata_valid_o[r_grant] = bus_rdata_valid_i;
                rdata_o                = bus_rdata_i;
                rdata_last_o           = bus_rdata_last_i;
                if (bus_rdata_valid_i && bus_rdata_last_i) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus_addr_o = r_addr;
    assign bus_we_o   = r_we;
    assign bus_len_o  = r_len;
    assign busy_o     = (r_state != S_IDLE);
endmodule

// File: tb/tb_core_cache_bus_arbiter.sv
// Randomized self-checking bench for core_cache_bus_arbiter; transaction-level model of grants and beats.
module tb_core_cache_bus_arbiter;
    localparam int LW = 8;
    localparam int AW = 32;
    localparam int DW = 32;
`ifdef CACHE_BUS_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [1:0]         req_valid_i = '0;
    logic [1:0]         req_ready_o;
    logic [1:0][AW-1:0] req_addr_i = '0;
    logic [1:0]         req_we_i = '0;
    logic [1:0][LW-1:0] req_len_i = '0;
    logic [1:0]         wdata_valid_i = '0;
    logic [1:0][DW-1:0] wdata_i = '0;
    logic [1:0]         wdata_ready_o;
    logic [1:0]         rdata_valid_o;
    logic [DW-1:0]      rdata_o;
    logic               rdata_last_o;
    logic [1:0]         wresp_valid_o;
    logic               bus_req_valid_o;
    logic               bus_req_ready_i = 1'b0;
    logic [AW-1:0]      bus_addr_o;
    logic               bus_we_o;
    logic [LW-1:0]      bus_len_o;
    logic               bus_wdata_valid_o;
    logic [DW-1:0]      bus_wdata_o;
    logic               bus_wdata_last_o;
    logic               bus_wdata_ready_i = 1'b0;
    logic               bus_rdata_valid_i = 1'b0;
    logic [DW-1:0]      bus_rdata_i = '0;
    logic               bus_rdata_last_i = 1'b0;
    logic               bus_wresp_valid_i = 1'b0;
    logic               busy_o;

    int total = 0;
    int bad   = 0;
    bit model_last = 1'b1;   // master granted most recently (reference model)

    core_cache_bus_arbiter #(.LEN_W(LW), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .req_we_i(req_we_i), .req_len_i(req_len_i),
        .wdata_valid_i(wdata_valid_i), .wdata_i(wdata_i), .wdata_ready_o(wdata_ready_o),
        .rdata_valid_o(rdata_valid_o), .rdata_o(rdata_o), .rdata_last_o(rdata_last_o),
        .wresp_valid_o(wresp_valid_o),
        .bus_req_valid_o(bus_req_valid_o), .bus_req_ready_i(bus_req_ready_i),
        .bus_addr_o(bus_addr_o), .bus_we_o(bus_we_o), .bus_len_o(bus_len_o),
        .bus_wdata_valid_o(bus_wdata_valid_o), .bus_wdata_o(bus_wdata_o),
        .bus_wdata_last_o(bus_wdata_last_o), .bus_wdata_ready_i(bus_wdata_ready_i),
        .bus_rdata_valid_i(bus_rdata_valid_i), .bus_rdata_i(bus_rdata_i),
        .bus_rdata_last_i(bus_rdata_last_i), .bus_wresp_valid_i(bus_wresp_valid_i),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic clear_bus();
        bus_req_ready_i = 1'b0; bus_wdata_ready_i = 1'b0; bus_rdata_valid_i = 1'b0;
        bus_rdata_last_i = 1'b0; bus_wresp_valid_i = 1'b0; wdata_valid_i = 2'b00;
    endtask

    // One full transaction starting in an IDLE cycle. vmask = requesting masters; hold keeps
    // requests asserted throughout; spur injects bus beats/responses that must be ignored;
    // rdy_mode 1 toggles bus_wdata_ready_i 1/0.
    task automatic run_txn(input logic [1:0] vmask, input bit hold, input bit spur, input bit rdy_mode);
        int m; int k; int guard; int wait_n;
        logic [1:0] expm; logic [DW-1:0] d; logic wv, rdy, bv;
        req_valid_i = vmask;
        if (vmask == 2'b11) m = RR ? int'(!model_last) : 1;
        else                m = vmask[1] ? 1 : 0;
        expm = 2'b01 << m;
        @(negedge clk);
        total++; if (req_ready_o !== expm) begin bad++; $display("FAIL grant got=%b exp=%b", req_ready_o, expm); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", busy_o); end
        @(posedge clk); #1;
        model_last = m[0];
        if (!hold) req_valid_i = 2'b00;
        wait_n = $urandom_range(0, 2);
        for (int w = 0; w <= wait_n; w++) begin
            bus_req_ready_i = (w == wait_n);
            @(negedge clk);
            total++; if (bus_req_valid_o !== 1'b1) begin bad++; $display("FAIL addr_valid got=%b exp=1", bus_req_valid_o); end
            total++; if ({bus_addr_o, bus_we_o, bus_len_o} !== {req_addr_i[m], req_we_i[m], req_len_i[m]})
                begin bad++; $display("FAIL addr_fields got=%h/%b/%0d exp=%h/%b/%0d", bus_addr_o, bus_we_o, bus_len_o, req_addr_i[m], req_we_i[m], req_len_i[m]); end
            total++; if (req_ready_o !== 2'b00 || busy_o !== 1'b1) begin bad++; $display("FAIL addr_hold got=%b/%b exp=00/1", req_ready_o, busy_o); end
            @(posedge clk); #1;
        end
        bus_req_ready_i = 1'b0;
        k = 0; guard = 0;
        if (req_we_i[m]) begin
            while (k <= int'(req_len_i[m]) && guard < 4000) begin
                wv  = ($urandom_range(0, 3) != 0);
                rdy = rdy_mode ? ~guard[0] : ($urandom_range(0, 2) != 0);
                d   = $urandom;
                wdata_valid_i = $urandom; wdata_i[1-m] = $urandom;
                wdata_valid_i[m] = wv; wdata_i[m] = d;
                bus_wdata_ready_i = rdy;
                bus_rdata_valid_i = spur & $urandom_range(0, 1);
                @(negedge clk);
                total++; if (bus_wdata_valid_o !== wv || (wv && bus_wdata_o !== d))
                    begin bad++; $display("FAIL wbeat got=%b/%h exp=%b/%h", bus_wdata_valid_o, bus_wdata_o, wv, d); end
                total++; if (wdata_ready_o !== (rdy ? expm : 2'b00)) begin bad++; $display("FAIL wready got=%b exp=%b", wdata_ready_o, rdy ? expm : 2'b00); end
                total++; if (bus_wdata_last_o !== (k == int'(req_len_i[m])))
                    begin bad++; $display("FAIL wlast beat=%0d got=%b exp=%b", k, bus_wdata_last_o, k == int'(req_len_i[m])); end
                total++; if (rdata_valid_o !== 2'b00 || busy_o !== 1'b1) begin bad++; $display("FAIL wphase_rd got=%b/%b exp=00/1", rdata_valid_o, busy_o); end
                @(posedge clk); #1;
                if (wv && rdy) k++;
                guard++;
            end
            clear_bus();
            total++; if (guard >= 4000) begin bad++; $display("FAIL wdata_timeout got=%0d exp=%0d", k, int'(req_len_i[m]) + 1); end
            wait_n = $urandom_range(0, 3);
            for (int w = 0; w <= wait_n; w++) begin
                bus_wresp_valid_i = (w == wait_n);
                bus_rdata_valid_i = spur & $urandom_range(0, 1);
                @(negedge clk);
                total++; if (wresp_valid_o !== ((w == wait_n) ? expm : 2'b00))
                    begin bad++; $display("FAIL wresp got=%b exp=%b", wresp_valid_o, (w == wait_n) ? expm : 2'b00); end
                total++; if (busy_o !== 1'b1 || rdata_valid_o !== 2'b00) begin bad++; $display("FAIL wresp_phase got=%b/%b exp=1/00", busy_o, rdata_valid_o); end
                @(posedge clk); #1;
            end
        end else begin
            while (k <= int'(req_len_i[m]) && guard < 4000) begin
                bv = ($urandom_range(0, 3) != 0);
                d  = $urandom;
                bus_rdata_valid_i = bv; bus_rdata_i = d;
                bus_rdata_last_i  = bv && (k == int'(req_len_i[m]));
                bus_wresp_valid_i = spur & $urandom_range(0, 1);
                wdata_valid_i = $urandom;
                @(negedge clk);
                total++; if (rdata_valid_o !== (bv ? expm : 2'b00)) begin bad++; $display("FAIL rvalid beat=%0d got=%b exp=%b", k, rdata_valid_o, bv ? expm : 2'b00); end
                total++; if (bv && (rdata_o !== d || rdata_last_o !== (k == int'(req_len_i[m]))))
                    begin bad++; $display("FAIL rbeat beat=%0d got=%h/%b exp=%h/%b", k, rdata_o, rdata_last_o, d, k == int'(req_len_i[m])); end
                total++; if (busy_o !== 1'b1 || wresp_valid_o !== 2'b00 || bus_wdata_valid_o !== 1'b0)
                    begin bad++; $display("FAIL rphase got=%b/%b/%b exp=1/00/0", busy_o, wresp_valid_o, bus_wdata_valid_o); end
                @(posedge clk); #1;
                if (bv) k++;
                guard++;
            end
            total++; if (guard >= 4000) begin bad++; $display("FAIL rdata_timeout got=%0d exp=%0d", k, int'(req_len_i[m]) + 1); end
        end
        clear_bus();
        if (!hold) begin
            @(negedge clk);
            total++; if (busy_o !== 1'b0 || rdata_valid_o !== 2'b00) begin bad++; $display("FAIL end_idle got=%b/%b exp=0/00", busy_o, rdata_valid_o); end
            @(posedge clk); #1;
        end
    endtask

    task automatic set_master(input int m, input logic [AW-1:0] a, input logic we, input logic [LW-1:0] len);
        req_addr_i[m] = a; req_we_i[m] = we; req_len_i[m] = len;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid_i = 2'b11; bus_rdata_valid_i = 1'b1; bus_wresp_valid_i = 1'b1; bus_rdata_last_i = 1'b1;
        @(negedge clk);
        total++; if (req_ready_o !== 2'b00 || busy_o !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b/%b exp=00/0", req_ready_o, busy_o); end
        total++; if (rdata_valid_o !== 2'b00 || rdata_last_o !== 1'b0 || wresp_valid_o !== 2'b00)
            begin bad++; $display("FAIL rst_resp got=%b/%b/%b exp=00/0/00", rdata_valid_o, rdata_last_o, wresp_valid_o); end
        total++; if ({bus_req_valid_o, bus_wdata_valid_o, bus_wdata_last_o} !== 3'b000 || bus_addr_o !== '0)
            begin bad++; $display("FAIL rst_bus got=%b%b%b/%h exp=000/0", bus_req_valid_o, bus_wdata_valid_o, bus_wdata_last_o, bus_addr_o); end
        req_valid_i = 2'b00; clear_bus();
        rst_n = 1'b1; model_last = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_icache_read();
        set_master(0, 32'h1C00_0000, 1'b0, 8'd7);
        run_txn(2'b01, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_dcache_write();
        set_master(1, $urandom, 1'b1, 8'd3);
        run_txn(2'b10, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_arbitration();
        test_reset();
        set_master(0, 32'h0000_1000, 1'b0, 8'd1);
        set_master(1, 32'h0000_2000, 1'b1, 8'd2);
        for (int i = 0; i < 4; i++) run_txn(2'b11, i != 3, 1'b0, 1'b0);
    endtask

    task automatic test_spurious();
        bus_rdata_valid_i = 1'b1; bus_wresp_valid_i = 1'b1; bus_rdata_last_i = 1'b1;
        bus_req_ready_i = 1'b1; bus_wdata_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (rdata_valid_o !== 2'b00 || wresp_valid_o !== 2'b00 || busy_o !== 1'b0 || bus_req_valid_o !== 1'b0)
                begin bad++; $display("FAIL spur_idle got=%b/%b/%b/%b exp=00/00/0/0", rdata_valid_o, wresp_valid_o, busy_o, bus_req_valid_o); end
            @(posedge clk); #1;
        end
        clear_bus();
        set_master(0, $urandom, 1'b1, 8'd5);
        run_txn(2'b01, 1'b0, 1'b1, 1'b0);
        set_master(1, $urandom, 1'b0, 8'd4);
        run_txn(2'b10, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_read();
        set_master(0, 32'h1C00_0100, 1'b0, 8'd7);
        req_valid_i = 2'b01;
        @(posedge clk); #1;
        req_valid_i = 2'b00; bus_req_ready_i = 1'b1;
        @(posedge clk); #1;
        bus_req_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus_rdata_valid_i = 1'b1; bus_rdata_i = $urandom;
            @(negedge clk);
            total++; if (rdata_valid_o !== 2'b01) begin bad++; $display("FAIL mid_beat got=%b exp=01", rdata_valid_o); end
            @(posedge clk); #1;
        end
        bus_rdata_valid_i = 1'b1; bus_rdata_last_i = 1'b1; req_valid_i = 2'b11;
        wdata_valid_i = 2'b11; bus_wdata_ready_i = 1'b1;
        rst_n = 1'b0; #1;
        total++; if (busy_o !== 1'b0 || rdata_valid_o !== 2'b00 || rdata_last_o !== 1'b0 || rdata_o !== '0)
            begin bad++; $display("FAIL mid_rst_rd got=%b/%b/%b/%h exp=0/00/0/0", busy_o, rdata_valid_o, rdata_last_o, rdata_o); end
        total++; if (req_ready_o !== 2'b00 || wdata_ready_o !== 2'b00 || {bus_req_valid_o, bus_wdata_valid_o, bus_wdata_last_o} !== 3'b000)
            begin bad++; $display("FAIL mid_rst_other got=%b/%b/%b%b%b exp=00/00/000", req_ready_o, wdata_ready_o, bus_req_valid_o, bus_wdata_valid_o, bus_wdata_last_o); end
        @(negedge clk);
        req_valid_i = 2'b00; clear_bus();
        rst_n = 1'b1; model_last = 1'b1;
        @(posedge clk); #1;
        set_master(1, 32'h2000_0040, 1'b1, 8'd2);
        run_txn(2'b10, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_max_len();
        set_master(0, $urandom, 1'b0, 8'd255);
        run_txn(2'b01, 1'b0, 1'b0, 1'b0);
        set_master(1, $urandom, 1'b1, 8'd255);
        run_txn(2'b10, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [1:0] vm;
        for (int i = 0; i < 12; i++) begin
            for (int j = 0; j < 2; j++) set_master(j, $urandom, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)));
            vm = 2'($urandom_range(1, 3));
            run_txn(vm, (i != 11) && ($urandom_range(0, 1) == 1), 1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_icache_read();
        test_dcache_write();
        test_arbitration();
        test_spurious();
        test_reset_mid_read();
        test_max_len();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
